aes_round_sched: RTL

Iterative AES encryption scheduler that reuses one round datapath for all `NR` rounds of a block. It accepts a plaintext block, performs the initial AddRoundKey, and issues one block/round-key pair per round to the external round datapath. It waits for each result, flags the final round so the datapath bypasses MixColumns, and presents the ciphertext with a ready/valid handshake. Round keys come from an external key store with a one-cycle read latency. The block sits between the block-level input interface and the shared round instance.

---
 rtl/aes_round_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// aes_round_sched: iterative AES scheduler feeding one shared round datapath.
// Define AES_SCHED_TIMEOUT_EN to enable the WAIT-state timeout abort and sticky err.
module aes_round_sched #(
  parameter int WORD    = 32,
  parameter int NB      = 4,
  parameter int NR      = 10,
  parameter int TIMEOUT = 15,
  localparam int B      = WORD * NB,
  localparam int RW     = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [B-1:0]  in_block,
  output logic [RW-1:0] rk_addr,
  input  logic [B-1:0]  rk_data,
  output logic          rnd_valid,
  output logic [B-1:0]  rnd_block,
  output logic [B-1:0]  rnd_key,
  output logic          rnd_final,
  input  logic          rnd_o_valid,
  input  logic [B-1:0]  rnd_o_block,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [B-1:0]  out_block,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_USE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [RW-1:0] LAST = RW'(NR);

  state_e        state_q, state_d;
  logic [B-1:0]  st_q, st_d;
  logic [B-1:0]  key_q, key_d;
  logic [RW-1:0] round_q, round_d;
  logic          issue;
  logic          tmo_hit;

  assign issue = (state_q == S_USE) && (round_q != '0);

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // tmo_q counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1
  assign tmo_hit = (state_q == S_WAIT) && !rnd_o_valid && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == S_IDLE && in_valid) err_d = 1'b0;
    if (issue) tmo_d = '0;
    else if (state_q == S_WAIT) tmo_d = tmo_q + 1'b1;
    if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_FETCH;
      S_FETCH: state_d = S_USE;
      S_USE:   state_d = (round_q == '0) ? S_FETCH : S_WAIT;
      S_WAIT: begin
        if (rnd_o_valid) state_d = (round_q == LAST) ? S_DONE : S_FETCH;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // round 0 is the initial AddRoundKey, done locally without the datapath
  always_comb begin
    st_d    = st_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = in_block;
          round_d = '0;
        end
      end
      S_USE: begin
        if (round_q == '0) begin
          st_d    = st_q ^ rk_data;
          round_d = RW'(1);
        end else begin
          key_d = rk_data;
        end
      end
      S_WAIT: begin
        if (rnd_o_valid) begin
          st_d = rnd_o_block;
          if (round_q != LAST) round_d = round_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rk_addr   = round_q;
    rnd_valid = issue;
    rnd_final = issue && (round_q == LAST);
    rnd_block = st_q;
    rnd_key   = issue ? rk_data : key_q;
    out_valid = (state_q == S_DONE);
    out_block = st_q;
`ifdef AES_SCHED_TIMEOUT_EN
    err       = err_q;
`else
    err       = 1'b0;
`endif
  end

endmodule
